// File: rtl/block_assembler_pkg.sv
// rtl/block_assembler_pkg.sv - shared defaults, control states and width helper for block_assembler
package block_assembler_pkg;

    localparam int DEF_IN_W      = 8;
    localparam int DEF_BLK_WORDS = 64;

    typedef enum logic [1:0] {
        ST_FILL,
        ST_XFER,
        ST_EMPTY_FLUSH
    } ctrl_state_e;

    function automatic int cnt_width(input int words);
        return $clog2(words + 1);
    endfunction

endpackage

// File: rtl/block_assembler.sv
// rtl/block_assembler.sv - packs IN_W-bit words into BLK_WORDS-word blocks with flush and back-pressure
module block_assembler
    import block_assembler_pkg::*;
#(
    parameter int IN_W       = DEF_IN_W,
    parameter int BLK_WORDS  = DEF_BLK_WORDS,
    localparam int BLK_W     = IN_W * BLK_WORDS,
    localparam int CNT_W     = cnt_width(BLK_WORDS)
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  in_data,
    output logic             in_ready,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [BLK_W-1:0] out_data,
    output logic [CNT_W-1:0] out_count
);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BLK_WORDS);

    logic [BLK_W-1:0] asm_data, asm_data_n;
    logic [CNT_W-1:0] asm_cnt, asm_cnt_n;
    logic             flush_pend, flush_pend_n;
    logic [BLK_W-1:0] out_data_n;
    logic [CNT_W-1:0] out_count_n;
    logic             out_valid_n;
    ctrl_state_e      state;
    logic             accept;
    logic             do_xfer;

    assign in_ready = (asm_cnt < FULL_CNT) && !flush_pend;
    assign accept   = in_valid && in_ready;

    always_comb begin
        if (asm_cnt == FULL_CNT || (flush_pend && asm_cnt != '0)) begin
            state = ST_XFER;
        end else if (flush_pend) begin
            state = ST_EMPTY_FLUSH;
        end else begin
            state = ST_FILL;
        end
    end

    assign do_xfer = (state == ST_XFER) && (!out_valid || out_ready);

    always_comb begin
        asm_data_n   = asm_data;
        asm_cnt_n    = asm_cnt;
        flush_pend_n = flush_pend;
        out_data_n   = out_data;
        out_count_n  = out_count;
        out_valid_n  = out_valid;

        if (out_valid && out_ready) begin
            out_valid_n = 1'b0;
        end

        // Newest word enters at the bottom, so a partial block stays right-aligned.
        if (accept) begin
            asm_data_n = {asm_data[BLK_W-IN_W-1:0], in_data};
            asm_cnt_n  = asm_cnt + CNT_W'(1);
        end

        if (state == ST_EMPTY_FLUSH) begin
            flush_pend_n = 1'b0;
        end else if (flush) begin
            flush_pend_n = 1'b1;
        end

        if (do_xfer) begin
            out_data_n   = asm_data;
            out_count_n  = asm_cnt;
            out_valid_n  = 1'b1;
            asm_data_n   = '0;
            asm_cnt_n    = '0;
            flush_pend_n = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            asm_data   <= '0;
            asm_cnt    <= '0;
            flush_pend <= 1'b0;
            out_data   <= '0;
            out_count  <= '0;
            out_valid  <= 1'b0;
        end else begin
            asm_data   <= asm_data_n;
            asm_cnt    <= asm_cnt_n;
            flush_pend <= flush_pend_n;
            out_data   <= out_data_n;
            out_count  <= out_count_n;
            out_valid  <= out_valid_n;
        end
    end

endmodule
